// File: rtl/jvm_byte_fetcher_pkg.sv
// Shared types and helpers for the JVM bytecode fetcher: fetch FSM encoding,
// word geometry and big-endian lane handling.
package jvm_byte_fetcher_pkg;

  localparam int WORD_BYTES = 4;
  localparam int FETCH_SM_W = 2;
  localparam int PUSH_CNT_W = $clog2(WORD_BYTES) + 1;

  typedef enum logic [FETCH_SM_W-1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_state_t;

  typedef logic [WORD_BYTES-1:0][7:0] word_lanes_t;

  // Lane 0 is the lowest byte address, which sits in bits [31:24] of the word.
  function automatic word_lanes_t split_word(input logic [31:0] word);
    word_lanes_t lanes;
    for (int i = 0; i < WORD_BYTES; i++) begin
      lanes[i] = word[31-8*i -: 8];
    end
    return lanes;
  endfunction

  // Keep only the lanes at or after the entry offset of an unaligned target.
  function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [1:0] skip);
    logic [WORD_BYTES-1:0] mask;
    for (int i = 0; i < WORD_BYTES; i++) begin
      mask[i] = (i >= int'(skip));
    end
    return mask;
  endfunction

endpackage

// File: rtl/jvm_byte_fetcher_fifo.sv
// Byte FIFO for the fetcher: accepts up to WORD_BYTES masked bytes per cycle,
// delivers one byte per pop, and reports its free-entry count.
module byte_fifo
  import jvm_byte_fetcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  word_lanes_t                  push_data_i,
  input  logic [WORD_BYTES-1:0]        push_mask_i,
  input  logic                         pop_i,
  output logic [7:0]                   head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       free_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PUSH_CNT_W-1:0] push_cnt;
  logic                  pop_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    push_cnt = '0;
    // Masked lanes are packed back to back starting at the write pointer.
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (push_mask_i[i]) begin
        mem_d[wr_ptr_q + PTR_W'(push_cnt)] = push_data_i[i];
        push_cnt = push_cnt + PUSH_CNT_W'(1);
      end
    end

    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_cnt) - CNT_W'(pop_ok);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign free_o  = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/jvm_byte_fetcher.sv
// Bytecode supply for the JIT translator: prefetches instruction-RAM words into
// a byte FIFO and hands out one bytecode per consume, with byte-granular redirects.
module jvm_byte_fetcher
  import jvm_byte_fetcher_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              consume,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [7:0]        iram_data,
  output logic              waiting,
  output logic [ADDR_W-1:0] byte_pc,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state_q;
  logic [ADDR_W-3:0]     fetch_word_q;
  logic [1:0]            skip_q;
  logic                  discard_q;
  logic                  mem_req_q;
  logic [ADDR_W-3:0]     mem_addr_q;
  logic [ADDR_W-1:0]     byte_pc_q, byte_pc_d;

  logic                  fifo_empty;
  logic [FREE_W-1:0]     fifo_free;
  logic [WORD_BYTES-1:0] push_mask;
  logic                  pop_req;
  logic                  room_for_word;

  always_comb begin
    push_mask = '0;
    if ((state_q == F_WAIT) && mem_rvalid && !discard_q && !redirect) begin
      push_mask = lane_mask(skip_q);
    end

    pop_req   = consume && !redirect;

    byte_pc_d = byte_pc_q;
    if (redirect) begin
      byte_pc_d = redirect_pc;
    end else if (consume && !fifo_empty) begin
      byte_pc_d = byte_pc_q + ADDR_W'(1);
    end
  end

  // Free space is judged before this cycle's pop, so a full word always fits.
  assign room_for_word = (fifo_free >= FREE_W'(WORD_BYTES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= F_IDLE;
      fetch_word_q <= '0;
      skip_q       <= '0;
      // A read already granted will still answer; remember to drop it.
      discard_q    <= (state_q == F_WAIT) || (discard_q && !mem_rvalid);
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      byte_pc_q    <= '0;
    end else begin
      byte_pc_q <= byte_pc_d;
      if (mem_rvalid) begin
        discard_q <= 1'b0;
      end

      if (redirect) begin
        fetch_word_q <= redirect_pc[ADDR_W-1:2];
        skip_q       <= redirect_pc[1:0];
        mem_req_q    <= 1'b0;
        unique case (state_q)
          F_REQ: begin
            if (mem_gnt) begin
              discard_q <= 1'b1;
              state_q   <= F_WAIT;
            end else begin
              state_q   <= F_IDLE;
            end
          end
          F_WAIT: begin
            // The in-flight word is stale; if it lands this very cycle it is simply not pushed.
            if (mem_rvalid) begin
              state_q   <= F_IDLE;
            end else begin
              discard_q <= 1'b1;
            end
          end
          default: state_q <= F_IDLE;
        endcase
      end else begin
        unique case (state_q)
          F_IDLE: begin
            if (room_for_word && !discard_q) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_word_q;
              state_q    <= F_REQ;
            end
          end
          F_REQ: begin
            if (mem_gnt) begin
              mem_req_q <= 1'b0;
              state_q   <= F_WAIT;
            end
          end
          F_WAIT: begin
            if (mem_rvalid) begin
              state_q <= F_IDLE;
              if (!discard_q) begin
                skip_q       <= '0;
                fetch_word_q <= fetch_word_q + 1'b1;
              end
            end
          end
          default: state_q <= F_IDLE;
        endcase
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_data_i (split_word(mem_rdata)),
    .push_mask_i (push_mask),
    .pop_i       (pop_req),
    .head_o      (iram_data),
    .empty_o     (fifo_empty),
    .free_o      (fifo_free)
  );

  assign waiting  = fifo_empty;
  assign byte_pc  = byte_pc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_jvm_byte_fetcher.sv
// Scoreboard bench for jvm_byte_fetcher: directed redirects and consumes against
// a behavioural instruction RAM; delivered bytes are checked by a monitor.
module tb_jvm_byte_fetcher;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              consume;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [7:0]        iram_data;
  logic              waiting;
  logic [ADDR_W-1:0] byte_pc;
  logic              mem_req;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  jvm_byte_fetcher #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .consume     (consume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iram_data   (iram_data),
    .waiting     (waiting),
    .byte_pc     (byte_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        data;
    logic [ADDR_W-1:0] pc;
  } exp_byte_t;

  int          total = 0;
  int          bad   = 0;
  exp_byte_t   sb_q[$];
  int unsigned req_log[$];
  logic [31:0] iram [64];

  int lat       = 1;
  int gnt_delay = 0;
  bit gnt_block = 1'b0;
  int pend_cnt  = 0;
  int pend_addr = 0;
  int req_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] data, input logic [ADDR_W-1:0] pc);
    exp_byte_t e;
    e.data = data;
    e.pc   = pc;
    sb_q.push_back(e);
  endtask

  function automatic int unsigned log_at(input int idx);
    if (idx < 0 || idx >= req_log.size()) return 32'hFFFF_FFFF;
    return req_log[idx];
  endfunction

  // Stimulus acts 2 time units after the edge, after the memory model has updated.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] pc, input logic with_consume);
    redirect    = 1'b1;
    redirect_pc = pc;
    consume     = with_consume;
    tick();
    redirect    = 1'b0;
    consume     = 1'b0;
  endtask

  task automatic wait_grant(input int unsigned addr, input int from_size, input int budget,
                            input string name);
    int cyc = 0;
    while (!(req_log.size() > from_size && req_log[$] == addr) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!(req_log.size() > from_size && req_log[$] == addr)) begin
      total++;
      bad++;
      $display("FAIL %s: no grant for word 0x%0h within %0d cycles", name, addr, budget);
    end
  endtask

  task automatic consume_bytes(input int n, input int budget, input string name);
    int left = n;
    int cyc  = 0;
    consume = 1'b1;
    while (left > 0 && cyc < budget) begin
      @(negedge clk);
      if (!waiting) left--;
      tick();
      cyc++;
      if (left == 0) consume = 1'b0;
    end
    consume = 1'b0;
    if (left > 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d bytes still undelivered after %0d cycles", name, left, budget);
    end
  endtask

  // Instruction RAM: grant after gnt_delay request cycles, answer lat cycles later.
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = iram[pend_addr];
        end
      end
      mem_gnt = 1'b0;
      if (mem_req && !reset) begin
        req_seen++;
        if (!gnt_block && req_seen > gnt_delay) begin
          mem_gnt   = 1'b1;
          req_seen  = 0;
          pend_cnt  = lat;
          pend_addr = int'(mem_addr[5:0]);
          req_log.push_back(int'(mem_addr));
        end
      end else begin
        req_seen = 0;
      end
    end
  end

  // Monitor: every byte the translator actually takes is compared with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && consume && !redirect && !waiting) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got byte 0x%0h at pc 0x%0h, none expected", iram_data, byte_pc);
        end else begin
          check("pop_data", 32'(iram_data), 32'(sb_q[0].data));
          check("pop_pc", 32'(byte_pc), 32'(sb_q[0].pc));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      iram[i] = {b, b ^ 8'h5A, ~b, b + 8'h11};
    end
    iram[0] = 32'h102A_B100;
    iram[1] = 32'hA1B2_C3D4;
    iram[2] = 32'h5566_7788;

    reset       = 1'b1;
    consume     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    check("rst_iram_data", 32'(iram_data), 32'h0);
    check("rst_waiting", 32'(waiting), 32'h1);
    check("rst_byte_pc", 32'(byte_pc), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Prefetch fills two words, then stalls with a full FIFO.
    for (int i = 0; i < 25; i++) tick();
    check("fill_req_count", 32'(req_log.size()), 32'd2);
    check("fill_addr0", log_at(0), 32'd0);
    check("fill_addr1", log_at(1), 32'd1);
    check("fill_mem_req", 32'(mem_req), 32'h0);
    check("fill_head", 32'(iram_data), 32'h10);
    check("fill_pc", 32'(byte_pc), 32'h0);

    expect_byte(8'h10, 16'h0000);
    consume_bytes(1, 20, "first_byte");
    for (int i = 0; i < 4; i++) tick();
    check("one_pop_no_req", 32'(mem_req), 32'h0);
    check("one_pop_req_count", 32'(req_log.size()), 32'd2);

    expect_byte(8'h2A, 16'h0001);
    expect_byte(8'hB1, 16'h0002);
    expect_byte(8'h00, 16'h0003);
    consume_bytes(3, 20, "word0_rest");
    wait_grant(2, 2, 10, "refill_word2");
    check("refill_addr", log_at(2), 32'd2);
    for (int i = 0; i < 8; i++) tick();

    // Redirect to word 1, then redirect again to 0x0006 while that read is in flight.
    lat  = 4;
    base = req_log.size();
    do_redirect(16'h0004, 1'b0);
    wait_grant(1, base, 20, "fetch_word1");
    tick();
    base = req_log.size();
    do_redirect(16'h0006, 1'b0);
    check("redir_waiting", 32'(waiting), 32'h1);
    check("redir_pc", 32'(byte_pc), 32'h0006);
    expect_byte(8'hC3, 16'h0006);
    expect_byte(8'hD4, 16'h0007);
    expect_byte(8'h55, 16'h0008);
    expect_byte(8'h66, 16'h0009);
    expect_byte(8'h77, 16'h000A);
    expect_byte(8'h88, 16'h000B);
    consume_bytes(6, 200, "unaligned_redirect");
    check("reissue_addr", log_at(base), 32'd1);

    // Consume held while waiting must neither move byte_pc nor underflow.
    lat       = 1;
    gnt_delay = 3;
    do_redirect(16'h0021, 1'b0);
    expect_byte(8'h52, 16'h0021);
    expect_byte(8'hF7, 16'h0022);
    expect_byte(8'h19, 16'h0023);
    expect_byte(8'h09, 16'h0024);
    consume = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("starve_waiting", 32'(waiting), 32'h1);
      check("starve_pc", 32'(byte_pc), 32'h0021);
      tick();
    end
    consume_bytes(4, 100, "after_starve");
    gnt_delay = 0;

    // Redirect with consume in the same cycle while three bytes are buffered.
    do_redirect(16'h0041, 1'b0);
    begin
      int cyc = 0;
      while (waiting && cyc < 50) begin
        tick();
        cyc++;
      end
    end
    gnt_block = 1'b1;
    check("three_head", 32'(iram_data), 32'h4A);
    check("three_pc", 32'(byte_pc), 32'h0041);
    tick();
    tick();
    check("blocked_last_grant", log_at(req_log.size() - 1), 32'd16);
    base = req_log.size();
    do_redirect(16'h0080, 1'b1);
    gnt_block = 1'b0;
    check("redir_consume_waiting", 32'(waiting), 32'h1);
    check("redir_consume_pc", 32'(byte_pc), 32'h0080);
    expect_byte(8'h20, 16'h0080);
    expect_byte(8'h7A, 16'h0081);
    expect_byte(8'hDF, 16'h0082);
    expect_byte(8'h31, 16'h0083);
    consume_bytes(4, 100, "after_redir_consume");
    check("redir_consume_addr", log_at(base), 32'd32);

    // Reset while a read is outstanding; its late response must be ignored.
    lat  = 3;
    base = req_log.size();
    do_redirect(16'h0010, 1'b0);
    wait_grant(4, base, 30, "fetch_word4");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_waiting", 32'(waiting), 32'h1);
    check("midrst_pc", 32'(byte_pc), 32'h0);
    check("midrst_mem_req", 32'(mem_req), 32'h0);
    base = req_log.size();
    expect_byte(8'h10, 16'h0000);
    expect_byte(8'h2A, 16'h0001);
    consume_bytes(2, 100, "after_midrst");
    check("midrst_refetch_addr", log_at(base), 32'd0);

    for (int i = 0; i < 4; i++) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
